// File: rtl/alu_cmd_sequencer.sv
// Purpose: initiator for the 8-bit ALU; turns a command into operand load and select, then samples and returns the result.
// Latency: command accepted at edge N -> res_valid high after edge N+2; one command per 4 cycles at best.
// Backpressure: cmd_ready is low until the response is taken; res_valid/res_data hold while res_ready is low.
module alu_cmd_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [2:0]       alu_in_sel,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] OP_CLEAR   = 3'd7;
  localparam logic [2:0] SEL_PERSIST = 3'b001;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_RESET   = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SAMPLE,
    RESP
  } state_t;

  state_t state;
  state_t nextState;
  logic   isClear;
  logic   cmdAccept;
  logic   resAccept;

  assign cmdAccept = cmd_valid && cmd_ready;
  assign resAccept = (state == RESP) && res_valid && res_ready;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state plus the handshake-ready and operand-register select, which are purely state-decoded.
  always_comb begin
    nextState  = state;
    cmd_ready  = 1'b0;
    alu_in_sel = SEL_PERSIST;
    if (reset) begin
      // Holding the ALU operand registers in reset for the whole reset period.
      alu_in_sel = SEL_RESET;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) nextState = LOAD;
        end
        LOAD: begin
          alu_in_sel = isClear ? SEL_RESET : SEL_LOAD;
          nextState  = SAMPLE;
        end
        SAMPLE: begin
          nextState = RESP;
        end
        RESP: begin
          if (res_valid && res_ready) nextState = IDLE;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // Operand/select capture on accept, result capture in SAMPLE, response handshake and op counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      isClear     <= 1'b0;
      alu_num1    <= '0;
      alu_num2    <= '0;
      alu_out_sel <= 7'b0000001;
      res_valid   <= 1'b0;
      res_data    <= '0;
      op_count    <= '0;
    end else begin
      if (cmdAccept) begin
        isClear <= (cmd_op == OP_CLEAR);
        if (cmd_op == OP_CLEAR) begin
          // CLEAR drives zero operands and leaves the operation select as it was.
          alu_num1 <= '0;
          alu_num2 <= '0;
        end else begin
          alu_num1    <= cmd_a;
          alu_num2    <= cmd_b;
          alu_out_sel <= 7'b0000001 << cmd_op;
        end
      end
      if (state == SAMPLE) begin
        res_data  <= isClear ? '0 : alu_result;
        res_valid <= 1'b1;
      end
      if (resAccept) begin
        res_valid <= 1'b0;
        op_count  <= op_count + 1'b1;
      end
    end
  end

endmodule
